if_id_reg: RTL and testbench

- Pipeline register between instruction fetch (PC register plus combinational instruction ROM) and instruction decode.
- Each cycle it captures the fetch PC and the ROM word, and presents the ID stage with pc, pc+4, instruction and a valid bit.
- It implements the stall (hold) and flush (bubble) rules, using the same priority as the PC register.
- It also suppresses the dummy fetch issued at INIT_PC immediately after reset.

---
 rtl/cpu_defs_pkg.sv | 12 +
 rtl/if_id_perf_cnt.sv | 34 +++
 rtl/if_id_reg.sv | 112 +++++++++++
 tb/tb_if_id_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch reset PC, canonical NOP encoding and the IF/ID state type.
package cpu_defs_pkg;

   localparam logic [31:0] INIT_PC_DEFAULT = 32'hfffffffc;
   localparam logic [31:0] NOP_INST        = 32'h00000013;

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } if_id_state_t;

endpackage

// File: rtl/if_id_perf_cnt.sv
// IF/ID performance counters: issued instructions, flush bubbles and stall cycles.
// All three are free-running 32-bit counters that wrap.
module if_id_perf_cnt (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        i_issue,
   input  logic        i_flush,
   input  logic        i_stall,
   output logic [31:0] o_issueCnt,
   output logic [31:0] o_flushCnt,
   output logic [31:0] o_stallCnt
);

   logic [31:0] r_issueCnt;
   logic [31:0] r_flushCnt;
   logic [31:0] r_stallCnt;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_issueCnt <= 32'h0;
         r_flushCnt <= 32'h0;
         r_stallCnt <= 32'h0;
      end else begin
         if (i_issue) r_issueCnt <= r_issueCnt + 32'd1;
         if (i_flush) r_flushCnt <= r_flushCnt + 32'd1;
         if (i_stall) r_stallCnt <= r_stallCnt + 32'd1;
      end
   end

   assign o_issueCnt = r_issueCnt;
   assign o_flushCnt = r_flushCnt;
   assign o_stallCnt = r_stallCnt;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > stall > advance priority and boot-fetch suppression.
// Define IF_ID_PERF_EN to build the perf counters; otherwise perf_* outputs are tied to zero.
module if_id_reg #(
   parameter logic [31:0] INIT_PC  = cpu_defs_pkg::INIT_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = cpu_defs_pkg::NOP_INST
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] if_pc_i,
   input  logic [31:0] if_inst_i,
   input  logic        data_suspend_i,
   input  logic        flush_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc4_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o,
   output logic [31:0] perf_issue_o,
   output logic [31:0] perf_flush_o,
   output logic [31:0] perf_stall_o
);

   import cpu_defs_pkg::*;

   if_id_state_t r_state;
   if_id_state_t w_nextState;
   logic         w_bubble;
   logic         w_advance;

   logic [31:0]  r_pc;
   logic [31:0]  r_pc4;
   logic [31:0]  r_inst;
   logic         r_valid;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= S_BOOT;
      else         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_BOOT:  w_nextState = S_RUN;
         S_RUN:   w_nextState = S_RUN;
         default: w_nextState = S_BOOT;
      endcase
   end

   // The boot edge is treated as a bubble so the dummy fetch at INIT_PC never issues.
   always_comb begin
      w_bubble  = 1'b0;
      w_advance = 1'b0;
      case (r_state)
         S_BOOT: w_bubble = 1'b1;
         S_RUN: begin
            if (flush_i)             w_bubble  = 1'b1;
            else if (!data_suspend_i) w_advance = 1'b1;
         end
         default: w_bubble = 1'b1;
      endcase
   end

   // A bubble still records the fetch PC so the ID stage shows where the pipe was redirected.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_pc    <= INIT_PC;
         r_pc4   <= 32'h0;
         r_inst  <= NOP_INST;
         r_valid <= 1'b0;
      end else if (w_bubble) begin
         r_pc    <= if_pc_i;
         r_pc4   <= if_pc_i + 32'd4;
         r_inst  <= NOP_INST;
         r_valid <= 1'b0;
      end else if (w_advance) begin
         r_pc    <= if_pc_i;
         r_pc4   <= if_pc_i + 32'd4;
         r_inst  <= if_inst_i;
         r_valid <= (if_pc_i != INIT_PC);
      end
   end

   assign id_pc_o    = r_pc;
   assign id_pc4_o   = r_pc4;
   assign id_inst_o  = r_inst;
   assign id_valid_o = r_valid;

`ifdef IF_ID_PERF_EN
   logic w_issueEv;
   logic w_flushEv;
   logic w_stallEv;

   assign w_flushEv = (r_state == S_RUN) && flush_i;
   assign w_stallEv = (r_state == S_RUN) && !flush_i && data_suspend_i;
   assign w_issueEv = w_advance && (if_pc_i != INIT_PC);

   if_id_perf_cnt u_perfCnt (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .i_issue    (w_issueEv),
      .i_flush    (w_flushEv),
      .i_stall    (w_stallEv),
      .o_issueCnt (perf_issue_o),
      .o_flushCnt (perf_flush_o),
      .o_stallCnt (perf_stall_o)
   );
`else
   assign perf_issue_o = 32'h0;
   assign perf_flush_o = 32'h0;
   assign perf_stall_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed pipeline scenarios plus randomized fetch streams
// compared against a behavioural model of the ID stage and its perf counters.
module tb_if_id_reg;

   localparam logic [31:0] BOOT_PC = 32'hfffffffc;
   localparam logic [31:0] NOP     = 32'h00000013;

   logic        clk_i;
   logic        reset_i;
   logic [31:0] if_pc_i;
   logic [31:0] if_inst_i;
   logic        data_suspend_i;
   logic        flush_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc4_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;
   logic [31:0] perf_issue_o;
   logic [31:0] perf_flush_o;
   logic [31:0] perf_stall_o;

   int checkCount;
   int errorCount;

`ifdef IF_ID_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   // Model of what ID should hold: the last accepted fetch, plus event tallies.
   bit          mBooted;
   logic [31:0] mPc;
   logic [31:0] mInst;
   bit          mValid;
   int unsigned mIssue;
   int unsigned mFlush;
   int unsigned mStall;

   if_id_reg dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .if_pc_i        (if_pc_i),
      .if_inst_i      (if_inst_i),
      .data_suspend_i (data_suspend_i),
      .flush_i        (flush_i),
      .id_pc_o        (id_pc_o),
      .id_pc4_o       (id_pc4_o),
      .id_inst_o      (id_inst_o),
      .id_valid_o     (id_valid_o),
      .perf_issue_o   (perf_issue_o),
      .perf_flush_o   (perf_flush_o),
      .perf_stall_o   (perf_stall_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mBooted = 1'b0;
      mPc     = BOOT_PC;
      mInst   = NOP;
      mValid  = 1'b0;
      mIssue  = 0;
      mFlush  = 0;
      mStall  = 0;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".pc"},    id_pc_o,  mPc);
      checkOutput({tag, ".pc4"},   id_pc4_o, (mBooted ? mPc + 32'd4 : 32'h0));
      checkOutput({tag, ".inst"},  id_inst_o, mInst);
      checkOutput({tag, ".valid"}, {31'h0, id_valid_o}, {31'h0, mValid});
      checkOutput({tag, ".issue"}, perf_issue_o, PERF_ON ? mIssue : 32'h0);
      checkOutput({tag, ".flush"}, perf_flush_o, PERF_ON ? mFlush : 32'h0);
      checkOutput({tag, ".stall"}, perf_stall_o, PERF_ON ? mStall : 32'h0);
   endtask

   // Drive one fetch cycle, let the edge happen, update the model, then compare.
   task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                                input bit susp, input bit flush);
      if_pc_i        = pc;
      if_inst_i      = inst;
      data_suspend_i = susp;
      flush_i        = flush;
      @(posedge clk_i);
      if (!mBooted) begin
         mBooted = 1'b1;
         mPc     = pc;
         mInst   = NOP;
         mValid  = 1'b0;
      end else if (flush) begin
         mPc    = pc;
         mInst  = NOP;
         mValid = 1'b0;
         mFlush++;
      end else if (susp) begin
         mStall++;
      end else begin
         mPc    = pc;
         mInst  = inst;
         mValid = (pc != BOOT_PC);
         if (mValid) mIssue++;
      end
      #1;
      checkAll(tag);
   endtask

   initial begin
      logic [31:0] pc;
      bit          lastFlush;
      bit          susp;
      bit          flush;
      checkCount = 0;
      errorCount = 0;
      if_pc_i        = BOOT_PC;
      if_inst_i      = 32'h0;
      data_suspend_i = 1'b0;
      flush_i        = 1'b0;
      reset_i        = 1'b1;
      modelReset();
      #2;
      checkAll("reset");
      #5 reset_i = 1'b0;

      applyStimulus("boot",  BOOT_PC, 32'hdeadbeef, 1'b0, 1'b0);
      applyStimulus("first", 32'h0,   32'h00100093, 1'b0, 1'b0);
      applyStimulus("pc4",   32'h4,   32'h00200113, 1'b0, 1'b0);
      applyStimulus("line",  32'h10,  32'h00500093, 1'b0, 1'b0);

      applyStimulus("ld20",  32'h20,  32'h00a00193, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus("stall", 32'h24, 32'h00b00213, 1'b1, 1'b0);
      applyStimulus("rel24", 32'h24,  32'h00b00213, 1'b0, 1'b0);

      applyStimulus("flSus", 32'h28,  32'h00c00293, 1'b1, 1'b1);
      applyStimulus("fl1",   32'h2c,  32'h00d00313, 1'b0, 1'b1);
      applyStimulus("fl2",   32'h30,  32'h00e00393, 1'b0, 1'b1);
      applyStimulus("npc",   32'h100, 32'h01000413, 1'b0, 1'b0);
      applyStimulus("wrap",  BOOT_PC, 32'h12345678, 1'b0, 1'b0);

      pc        = 32'h200;
      lastFlush = 1'b0;
      for (int i = 0; i < 300; i++) begin
         flush = ($urandom_range(0, 7) == 0);
         susp  = ($urandom_range(0, 3) == 0);
         if (lastFlush)                         pc = {$urandom_range(0, 32'h3fff), 2'b00};
         else if ($urandom_range(0, 19) == 0)   pc = BOOT_PC;
         applyStimulus("rand", pc, $urandom, susp, flush);
         lastFlush = flush;
         if (!flush && !susp) pc = pc + 32'd4;
      end

      // Asynchronous reset between edges must clear the outputs without a clock.
      #3 reset_i = 1'b1;
      modelReset();
      #1 checkAll("asyncRst");
      #1 reset_i = 1'b0;
      applyStimulus("reboot", 32'h40, 32'h00f00493, 1'b1, 1'b1);
      applyStimulus("rerun",  32'h44, 32'h01100513, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
